// File: rtl/osd_nasti_pkg.sv
// Shared NASTI response/burst encodings, response merge and bridge FSM states
// for the UART DEM NASTI bridge.
package osd_nasti_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StWrData,
      StWrReq,
      StWrWait,
      StBSend,
      StRdReq,
      StRdWait,
      StRSend
   } bridge_state_e;

   // Encodings are ordered by severity, so the worse response is the larger code.
   function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/osd_dem_uart_nasti_beat.sv
// Per-transaction beat tracker: address, length, beat counter, lane and legality.
// Address window check enabled by OSD_DEM_UART_BRIDGE_ADDR_CHECK_EN.
module osd_dem_uart_nasti_beat
   import osd_nasti_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LANES = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
   localparam int unsigned LaneBits = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic                  advance_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [7:0]            len_i,
   input  logic [2:0]            size_i,
   input  logic [1:0]            burst_i,
   output logic [2:0]            addr_o,
   output logic [LaneBits-1:0]   lane_o,
   output logic                  last_o,
   output logic                  slverr_o,
   output logic                  decerr_o
);

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [7:0]            cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= BURST_FIXED;
         cnt_q   <= '0;
      end else if (load_i) begin
         addr_q  <= addr_i;
         len_q   <= len_i;
         size_q  <= size_i;
         burst_q <= burst_i;
         cnt_q   <= '0;
      end else if (advance_i) begin
         cnt_q <= cnt_q + 8'd1;
         if (burst_q == BURST_INCR) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
         end
      end
   end

   assign addr_o   = addr_q[2:0];
   assign last_o   = (cnt_q == len_q);
   assign slverr_o = (size_q != 3'd0) || (burst_q == BURST_WRAP);

   if (LANES > 1) begin : g_lane
      assign lane_o = addr_q[LaneBits-1:0];
   end else begin : g_lane_single
      assign lane_o = '0;
   end

`ifdef OSD_DEM_UART_BRIDGE_ADDR_CHECK_EN
   assign decerr_o = (addr_q[ADDR_WIDTH-1:3] != BASE_ADDR[ADDR_WIDTH-1:3]);
`else
   logic [ADDR_WIDTH-1:0] unused_base;
   assign unused_base = BASE_ADDR;
   assign decerr_o    = 1'b0;
`endif

endmodule

// File: rtl/osd_dem_uart_nasti_bridge.sv
// Full NASTI host port to byte-wide NASTI-lite UART port; one transaction in flight.
// Optional address window check: OSD_DEM_UART_BRIDGE_ADDR_CHECK_EN.
module osd_dem_uart_nasti_bridge
   import osd_nasti_pkg::*;
#(
   parameter int unsigned ID_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ID_WIDTH-1:0]     s_aw_id,
   input  logic [ADDR_WIDTH-1:0]   s_aw_addr,
   input  logic [7:0]              s_aw_len,
   input  logic [2:0]              s_aw_size,
   input  logic [1:0]              s_aw_burst,
   input  logic                    s_aw_valid,
   output logic                    s_aw_ready,
   input  logic [DATA_WIDTH-1:0]   s_w_data,
   input  logic [DATA_WIDTH/8-1:0] s_w_strb,
   input  logic                    s_w_last,
   input  logic                    s_w_valid,
   output logic                    s_w_ready,
   output logic [ID_WIDTH-1:0]     s_b_id,
   output logic [1:0]              s_b_resp,
   output logic                    s_b_valid,
   input  logic                    s_b_ready,
   input  logic [ID_WIDTH-1:0]     s_ar_id,
   input  logic [ADDR_WIDTH-1:0]   s_ar_addr,
   input  logic [7:0]              s_ar_len,
   input  logic [2:0]              s_ar_size,
   input  logic [1:0]              s_ar_burst,
   input  logic                    s_ar_valid,
   output logic                    s_ar_ready,
   output logic [ID_WIDTH-1:0]     s_r_id,
   output logic [DATA_WIDTH-1:0]   s_r_data,
   output logic [1:0]              s_r_resp,
   output logic                    s_r_last,
   output logic                    s_r_valid,
   input  logic                    s_r_ready,
   output logic [2:0]              m_aw_addr,
   output logic                    m_aw_valid,
   input  logic                    m_aw_ready,
   output logic [7:0]              m_w_data,
   output logic                    m_w_valid,
   input  logic                    m_w_ready,
   input  logic [1:0]              m_b_resp,
   input  logic                    m_b_valid,
   output logic                    m_b_ready,
   output logic [2:0]              m_ar_addr,
   output logic                    m_ar_valid,
   input  logic                    m_ar_ready,
   input  logic [7:0]              m_r_data,
   input  logic [1:0]              m_r_resp,
   input  logic                    m_r_valid,
   output logic                    m_r_ready
);

   localparam int unsigned LANES = DATA_WIDTH / 8;
   localparam int unsigned LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;

   bridge_state_e state_q, state_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic [1:0]          resp_q, resp_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [7:0]          wdata_q, wdata_d;
   logic [7:0]          rdata_q, rdata_d;
   logic                wlast_q, wlast_d;

   logic                  beat_load, beat_advance;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [7:0]            ld_len;
   logic [2:0]            ld_size;
   logic [1:0]            ld_burst;
   logic [2:0]            beat_addr;
   logic [LANE_BITS-1:0]  beat_lane;
   logic                  beat_last, beat_slverr, beat_decerr;

   osd_dem_uart_nasti_beat #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANES      (LANES),
      .BASE_ADDR  (BASE_ADDR)
   ) u_beat (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (beat_load),
      .advance_i (beat_advance),
      .addr_i    (ld_addr),
      .len_i     (ld_len),
      .size_i    (ld_size),
      .burst_i   (ld_burst),
      .addr_o    (beat_addr),
      .lane_o    (beat_lane),
      .last_o    (beat_last),
      .slverr_o  (beat_slverr),
      .decerr_o  (beat_decerr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         id_q    <= '0;
         resp_q  <= RESP_OKAY;
         rresp_q <= RESP_OKAY;
         wdata_q <= '0;
         rdata_q <= '0;
         wlast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         resp_q  <= resp_d;
         rresp_q <= rresp_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wlast_q <= wlast_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      resp_d       = resp_q;
      rresp_d      = rresp_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      wlast_d      = wlast_q;
      beat_load    = 1'b0;
      beat_advance = 1'b0;
      ld_addr      = s_aw_addr;
      ld_len       = s_aw_len;
      ld_size      = s_aw_size;
      ld_burst     = s_aw_burst;
      s_aw_ready   = 1'b0;
      s_w_ready    = 1'b0;
      s_b_valid    = 1'b0;
      s_b_id       = id_q;
      s_b_resp     = resp_q;
      s_ar_ready   = 1'b0;
      s_r_valid    = 1'b0;
      s_r_id       = id_q;
      s_r_resp     = rresp_q;
      s_r_last     = beat_last;
      s_r_data     = '0;
      m_aw_addr    = beat_addr;
      m_aw_valid   = 1'b0;
      m_w_data     = wdata_q;
      m_w_valid    = 1'b0;
      m_b_ready    = 1'b0;
      m_ar_addr    = beat_addr;
      m_ar_valid   = 1'b0;
      m_r_ready    = 1'b0;

      unique case (state_q)
         StIdle: begin
            s_aw_ready = s_aw_valid;
            s_ar_ready = s_ar_valid & ~s_aw_valid;
            if (s_aw_valid) begin
               id_d      = s_aw_id;
               resp_d    = RESP_OKAY;
               beat_load = 1'b1;
               state_d   = StWrData;
            end else if (s_ar_valid) begin
               id_d      = s_ar_id;
               ld_addr   = s_ar_addr;
               ld_len    = s_ar_len;
               ld_size   = s_ar_size;
               ld_burst  = s_ar_burst;
               beat_load = 1'b1;
               state_d   = StRdReq;
            end
         end
         StWrData: begin
            s_w_ready = 1'b1;
            if (s_w_valid) begin
               wdata_d = s_w_data[8*beat_lane +: 8];
               wlast_d = s_w_last;
               if ((s_w_last != beat_last) || beat_slverr) begin
                  resp_d = resp_merge(resp_d, RESP_SLVERR);
               end
               if (beat_decerr) begin
                  resp_d = resp_merge(resp_d, RESP_DECERR);
               end
               // Masked or illegal beats are consumed here without a downstream access.
               if (!s_w_strb[beat_lane] || beat_slverr || beat_decerr) begin
                  beat_advance = 1'b1;
                  state_d      = s_w_last ? StBSend : StWrData;
               end else begin
                  state_d = StWrReq;
               end
            end
         end
         StWrReq: begin
            m_aw_valid = 1'b1;
            m_w_valid  = 1'b1;
            if (m_aw_ready && m_w_ready) begin
               state_d = StWrWait;
            end
         end
         StWrWait: begin
            m_b_ready = 1'b1;
            if (m_b_valid) begin
               resp_d       = resp_merge(resp_q, m_b_resp);
               beat_advance = 1'b1;
               state_d      = wlast_q ? StBSend : StWrData;
            end
         end
         StBSend: begin
            s_b_valid = 1'b1;
            if (s_b_ready) begin
               state_d = StIdle;
            end
         end
         StRdReq: begin
            if (beat_slverr || beat_decerr) begin
               rdata_d = '0;
               rresp_d = beat_decerr ? RESP_DECERR : RESP_SLVERR;
               state_d = StRSend;
            end else begin
               m_ar_valid = 1'b1;
               if (m_ar_ready) begin
                  state_d = StRdWait;
               end
            end
         end
         StRdWait: begin
            m_r_ready = 1'b1;
            if (m_r_valid) begin
               rdata_d = m_r_data;
               rresp_d = m_r_resp;
               state_d = StRSend;
            end
         end
         StRSend: begin
            s_r_valid                  = 1'b1;
            s_r_data[8*beat_lane +: 8] = rdata_q;
            if (s_r_ready) begin
               beat_advance = 1'b1;
               state_d      = beat_last ? StIdle : StRdReq;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_osd_dem_uart_nasti_bridge.sv
// Directed bench for osd_dem_uart_nasti_bridge with a byte-port responder model.
// DECERR vectors run only when OSD_DEM_UART_BRIDGE_ADDR_CHECK_EN is defined.
module tb_osd_dem_uart_nasti_bridge;
   import osd_nasti_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  s_aw_id, s_ar_id, s_b_id, s_r_id;
   logic [31:0] s_aw_addr, s_ar_addr;
   logic [7:0]  s_aw_len, s_ar_len;
   logic [2:0]  s_aw_size, s_ar_size;
   logic [1:0]  s_aw_burst, s_ar_burst;
   logic        s_aw_valid, s_aw_ready, s_ar_valid, s_ar_ready;
   logic [63:0] s_w_data, s_r_data;
   logic [7:0]  s_w_strb;
   logic        s_w_last, s_w_valid, s_w_ready;
   logic [1:0]  s_b_resp, s_r_resp;
   logic        s_b_valid, s_b_ready, s_r_last, s_r_valid, s_r_ready;
   logic [2:0]  m_aw_addr, m_ar_addr;
   logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
   logic [7:0]  m_w_data, m_r_data;
   logic [1:0]  m_b_resp, m_r_resp;
   logic        m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;

   osd_dem_uart_nasti_bridge #(
      .ID_WIDTH   (4),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (64),
      .BASE_ADDR  (32'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_aw_id(s_aw_id), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len), .s_aw_size(s_aw_size),
      .s_aw_burst(s_aw_burst), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
      .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last), .s_w_valid(s_w_valid),
      .s_w_ready(s_w_ready),
      .s_b_id(s_b_id), .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
      .s_ar_id(s_ar_id), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
      .s_ar_burst(s_ar_burst), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
      .s_r_id(s_r_id), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
      .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
      .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
      .m_w_data(m_w_data), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
      .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
      .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
      .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Responder state: written only by the responder process.
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   logic [2:0] wr_addr [16];
   logic [7:0] wr_data [16];
   logic [2:0] ar_addr [16];
   logic [7:0] rd_table [16];
   int         b_stall = 0;
   int         b_cnt = 0;
   logic       b_pend = 0, b_done = 0, r_pend = 0, r_done = 0;
   logic [7:0] r_next = '0;

   // Works at negedges: retires handshakes of the previous posedge, then predicts the next.
   initial begin
      m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
      m_b_valid = 1'b0; m_b_resp = RESP_OKAY;
      m_r_valid = 1'b0; m_r_data = '0; m_r_resp = RESP_OKAY;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_b_valid = 1'b0; m_r_valid = 1'b0;
            b_pend = 1'b0; b_done = 1'b0; r_pend = 1'b0; r_done = 1'b0;
         end else begin
            if (b_done) begin m_b_valid = 1'b0; b_done = 1'b0; end
            if (r_done) begin m_r_valid = 1'b0; r_done = 1'b0; end
            if (b_pend) begin
               if (b_cnt == 0) begin m_b_valid = 1'b1; m_b_resp = RESP_OKAY; b_pend = 1'b0; end
               else b_cnt--;
            end
            if (r_pend) begin m_r_valid = 1'b1; m_r_data = r_next; r_pend = 1'b0; end
            if (m_aw_valid && m_w_valid) begin
               wr_addr[wr_cnt % 16] = m_aw_addr;
               wr_data[wr_cnt % 16] = m_w_data;
               wr_cnt++;
               b_pend = 1'b1;
               b_cnt  = b_stall;
            end
            if (m_ar_valid) begin
               ar_addr[rd_cnt % 16] = m_ar_addr;
               r_next = rd_table[rd_cnt % 16];
               rd_cnt++;
               r_pend = 1'b1;
            end
            if (m_b_valid && m_b_ready) b_done = 1'b1;
            if (m_r_valid && m_r_ready) r_done = 1'b1;
         end
      end
   end

   task automatic host_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      s_aw_id = id; s_aw_addr = addr; s_aw_len = len; s_aw_size = size; s_aw_burst = burst;
      s_aw_valid = 1'b1;
      #1;
      while (!s_aw_ready && n < 50) begin @(negedge clk); #1; n++; end
      check("aw_accept", s_aw_ready, 1);
      @(posedge clk); #1;
      s_aw_valid = 1'b0;
   endtask

   task automatic host_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int n = 0;
      s_ar_id = id; s_ar_addr = addr; s_ar_len = len; s_ar_size = size; s_ar_burst = burst;
      s_ar_valid = 1'b1;
      #1;
      while (!s_ar_ready && n < 50) begin @(negedge clk); #1; n++; end
      check("ar_accept", s_ar_ready, 1);
      @(posedge clk); #1;
      s_ar_valid = 1'b0;
   endtask

   task automatic host_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n = 0;
      s_w_data = data; s_w_strb = strb; s_w_last = last; s_w_valid = 1'b1;
      #1;
      while (!s_w_ready && n < 50) begin @(negedge clk); #1; n++; end
      check("w_accept", s_w_ready, 1);
      @(posedge clk); #1;
      s_w_valid = 1'b0;
   endtask

   task automatic wait_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
      int n = 0;
      while (!s_b_valid && n < 100) begin @(negedge clk); n++; end
      check({tag, "_bvalid"}, s_b_valid, 1);
      check({tag, "_bid"}, s_b_id, id);
      check({tag, "_bresp"}, s_b_resp, resp);
      s_b_ready = 1'b1;
      @(posedge clk); #1;
      s_b_ready = 1'b0;
   endtask

   task automatic wait_r(input string tag, input logic [3:0] id, input logic [63:0] data,
                         input logic [1:0] resp, input logic last, input int stall);
      int n = 0;
      while (!s_r_valid && n < 100) begin @(negedge clk); n++; end
      check({tag, "_rvalid"}, s_r_valid, 1);
      if (stall > 0) begin
         repeat (stall) @(negedge clk);
         check({tag, "_hold"}, s_r_valid, 1);
      end
      check({tag, "_rid"}, s_r_id, id);
      check({tag, "_rdata"}, s_r_data, data);
      check({tag, "_rresp"}, s_r_resp, resp);
      check({tag, "_rlast"}, s_r_last, last);
      s_r_ready = 1'b1;
      @(posedge clk); #1;
      s_r_ready = 1'b0;
   endtask

   initial begin
      int wb, rb, n;
      s_aw_id = '0; s_aw_addr = '0; s_aw_len = '0; s_aw_size = '0; s_aw_burst = '0;
      s_ar_id = '0; s_ar_addr = '0; s_ar_len = '0; s_ar_size = '0; s_ar_burst = '0;
      s_aw_valid = 1'b0; s_ar_valid = 1'b0; s_w_valid = 1'b0; s_w_data = '0;
      s_w_strb = '0; s_w_last = 1'b0; s_b_ready = 1'b0; s_r_ready = 1'b0;
      for (int i = 0; i < 16; i++) rd_table[i] = 8'h00;

      repeat (3) @(negedge clk);
      #1;
      check("reset_hs", {s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid, m_aw_valid,
                         m_w_valid, m_b_ready, m_ar_valid, m_r_ready}, 10'b0);
      check("reset_bresp", s_b_resp, RESP_OKAY);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-byte write on lane 3
      wb = wr_cnt;
      host_aw(4'h5, 32'h3, 8'd0, 3'd0, BURST_INCR);
      host_w(64'hA5 << 24, 8'h08, 1'b1);
      wait_b("wr1", 4'h5, RESP_OKAY);
      check("wr1_cnt", wr_cnt - wb, 1);
      check("wr1_addr", wr_addr[wb % 16], 3'd3);
      check("wr1_data", wr_data[wb % 16], 8'hA5);

      // INCR read burst of 4, one R beat stalled by the host
      rb = rd_cnt;
      rd_table[(rb + 0) % 16] = 8'h11;
      rd_table[(rb + 1) % 16] = 8'h22;
      rd_table[(rb + 2) % 16] = 8'h33;
      rd_table[(rb + 3) % 16] = 8'h44;
      host_ar(4'h2, 32'h0, 8'd3, 3'd0, BURST_INCR);
      wait_r("rd0", 4'h2, 64'h11, RESP_OKAY, 1'b0, 0);
      wait_r("rd1", 4'h2, 64'h2200, RESP_OKAY, 1'b0, 5);
      wait_r("rd2", 4'h2, 64'h330000, RESP_OKAY, 1'b0, 0);
      wait_r("rd3", 4'h2, 64'h44000000, RESP_OKAY, 1'b1, 0);
      check("rd_cnt", rd_cnt - rb, 4);
      check("rd_ar3", ar_addr[(rb + 3) % 16], 3'd3);

      // Simultaneous AW and AR: write first, read after B
      wb = wr_cnt;
      rb = rd_cnt;
      rd_table[rb % 16] = 8'h5A;
      @(negedge clk);
      s_aw_id = 4'h1; s_aw_addr = 32'h5; s_aw_len = 8'd0; s_aw_size = 3'd0;
      s_aw_burst = BURST_INCR; s_aw_valid = 1'b1;
      s_ar_id = 4'h7; s_ar_addr = 32'h6; s_ar_len = 8'd0; s_ar_size = 3'd0;
      s_ar_burst = BURST_FIXED; s_ar_valid = 1'b1;
      #1;
      check("tie_aw_ready", s_aw_ready, 1);
      check("tie_ar_ready0", s_ar_ready, 0);
      @(posedge clk); #1;
      s_aw_valid = 1'b0;
      host_w(64'h3C << 40, 8'h20, 1'b1);
      check("tie_ar_busy", s_ar_ready, 0);
      wait_b("tie", 4'h1, RESP_OKAY);
      check("tie_ar_ready1", s_ar_ready, 1);
      @(posedge clk); #1;
      s_ar_valid = 1'b0;
      wait_r("tie", 4'h7, 64'h5A << 48, RESP_OKAY, 1'b1, 0);
      check("tie_wdata", wr_data[wb % 16], 8'h3C);
      check("tie_waddr", wr_addr[wb % 16], 3'd5);
      check("tie_araddr", ar_addr[rb % 16], 3'd6);

      // Illegal size and masked strobe: no downstream access
      wb = wr_cnt;
      host_aw(4'h3, 32'h0, 8'd0, 3'd2, BURST_INCR);
      host_w(64'hFFFF_FFFF, 8'h0F, 1'b1);
      wait_b("size2", 4'h3, RESP_SLVERR);
      host_aw(4'h4, 32'h2, 8'd0, 3'd0, BURST_INCR);
      host_w(64'hFF << 16, 8'h00, 1'b1);
      wait_b("strb0", 4'h4, RESP_OKAY);
      check("skip_cnt", wr_cnt - wb, 0);

      // Early w_last on beat 2 of a len=3 burst, with m_b stalled
      wb = wr_cnt;
      b_stall = 5;
      host_aw(4'h6, 32'h0, 8'd3, 3'd0, BURST_INCR);
      host_w(64'h01, 8'h01, 1'b0);
      host_w(64'h0200, 8'h02, 1'b1);
      wait_b("early", 4'h6, RESP_SLVERR);
      check("early_cnt", wr_cnt - wb, 2);
      check("early_d0", wr_data[wb % 16], 8'h01);
      check("early_a1", wr_addr[(wb + 1) % 16], 3'd1);
      check("early_d1", wr_data[(wb + 1) % 16], 8'h02);

      // Reset while waiting for m_b
      b_stall = 20;
      host_aw(4'h2, 32'h7, 8'd0, 3'd0, BURST_INCR);
      host_w(64'h77 << 56, 8'h80, 1'b1);
      n = 0;
      while (!m_b_ready && n < 50) begin @(negedge clk); n++; end
      check("rst_in_wait", m_b_ready, 1);
      rst_n = 1'b0;
      #1;
      check("rst_abort", {s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid, m_aw_valid,
                          m_w_valid, m_b_ready, m_ar_valid, m_r_ready}, 10'b0);
      repeat (2) @(negedge clk);
      b_stall = 0;
      rst_n = 1'b1;
      @(negedge clk);
      wb = wr_cnt;
      host_aw(4'h9, 32'h1, 8'd0, 3'd0, BURST_INCR);
      host_w(64'hC3 << 8, 8'h02, 1'b1);
      wait_b("post_rst", 4'h9, RESP_OKAY);
      check("post_rst_d", wr_data[wb % 16], 8'hC3);

`ifdef OSD_DEM_UART_BRIDGE_ADDR_CHECK_EN
      // Read outside the UART window
      rb = rd_cnt;
      host_ar(4'h3, 32'h100, 8'd0, 3'd0, BURST_INCR);
      wait_r("decerr", 4'h3, 64'h0, RESP_DECERR, 1'b1, 0);
      check("decerr_cnt", rd_cnt - rb, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
